// File: rtl/wb_soc_arb_pkg.sv
// Shared definitions for the two-master Wishbone CPU bus arbiter:
// FSM state codes, burst-type constants and the stall-counter width.
package wb_soc_arb_pkg;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t ST_IDLE  = 2'd0;
    localparam arb_state_t ST_OWN0  = 2'd1;
    localparam arb_state_t ST_OWN1  = 2'd2;
    localparam arb_state_t ST_ABORT = 2'd3;

    localparam logic [2:0] CTI_CLASSIC      = 3'b000;
    localparam logic [2:0] CTI_INCR_BURST   = 3'b010;
    localparam logic [2:0] CTI_END_OF_BURST = 3'b111;

    localparam int STALL_CNT_W = 8;

    // One-hot grant vector for a state: bit0 = m0, bit1 = m1.
    function automatic logic [1:0] grant_of(arb_state_t st);
        return {st == ST_OWN1, st == ST_OWN0};
    endfunction

endpackage

// File: rtl/wb_bus_watchdog.sv
// Stall watchdog: counts consecutive unanswered strobe cycles and flags the
// cycle in which the LIMIT-th such cycle occurs.
module wb_bus_watchdog
    import wb_soc_arb_pkg::*;
#(
    parameter int LIMIT = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en,
    input  logic clr,
    output logic expired
);

    localparam logic [STALL_CNT_W-1:0] LAST = STALL_CNT_W'(LIMIT - 1);

    logic [STALL_CNT_W-1:0] cnt;

    // NOTE: sequential state is written with non-blocking assignments only, so
    // every flop samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr) begin
            cnt <= '0;
        end else if (en && cnt != '1) begin
            cnt <= cnt + STALL_CNT_W'(1);
        end
    end

    // Asserted during the stall cycle that would make the count reach LIMIT,
    // so a termination in that same cycle (which drops en) still wins.
    assign expired = en && (cnt == LAST);

endmodule

// File: rtl/wb_cpu_bus_arbiter.sv
// Two-master (instruction m0, data m1) Wishbone arbiter onto one slave bus,
// round-robin on ties, no preemption, with a stall timeout that forces err.
module wb_cpu_bus_arbiter
    import wb_soc_arb_pkg::*;
#(
    parameter int ADDRESS_WIDTH  = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                     clk_i,
    input  logic                     rst_i,

    input  logic                     m0_cyc_i,
    input  logic                     m0_stb_i,
    input  logic                     m0_we_i,
    input  logic [ADDRESS_WIDTH-1:0] m0_adr_i,
    input  logic [DATA_WIDTH-1:0]    m0_dat_i,
    input  logic [3:0]               m0_sel_i,
    input  logic [2:0]               m0_cti_i,
    input  logic [1:0]               m0_bte_i,
    output logic                     m0_ack_o,
    output logic                     m0_err_o,
    output logic                     m0_rty_o,
    output logic [DATA_WIDTH-1:0]    m0_dat_o,

    input  logic                     m1_cyc_i,
    input  logic                     m1_stb_i,
    input  logic                     m1_we_i,
    input  logic [ADDRESS_WIDTH-1:0] m1_adr_i,
    input  logic [DATA_WIDTH-1:0]    m1_dat_i,
    input  logic [3:0]               m1_sel_i,
    input  logic [2:0]               m1_cti_i,
    input  logic [1:0]               m1_bte_i,
    output logic                     m1_ack_o,
    output logic                     m1_err_o,
    output logic                     m1_rty_o,
    output logic [DATA_WIDTH-1:0]    m1_dat_o,

    output logic                     s_cyc_o,
    output logic                     s_stb_o,
    output logic                     s_we_o,
    output logic [ADDRESS_WIDTH-1:0] s_adr_o,
    output logic [DATA_WIDTH-1:0]    s_dat_o,
    output logic [3:0]               s_sel_o,
    output logic [2:0]               s_cti_o,
    output logic [1:0]               s_bte_o,
    input  logic                     s_ack_i,
    input  logic                     s_err_i,
    input  logic                     s_rty_i,
    input  logic [DATA_WIDTH-1:0]    s_dat_i,

    output logic [1:0]               grant_o,
    output logic                     timeout_o
);

    arb_state_t state, state_d;
    logic       last_owner;   // 0: m0 owned last, 1: m1 owned last
    logic       owner;        // current/aborted owner, valid outside IDLE
    logic       own0, own1, owned, aborting, term;
    logic       stall_en, stall_clr, stall_expired;

    assign own0     = (state == ST_OWN0);
    assign own1     = (state == ST_OWN1);
    assign owned    = own0 || own1;
    assign aborting = (state == ST_ABORT);
    assign term     = s_ack_i || s_err_i || s_rty_i;

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path through the case/if tree can leave it unassigned and infer a latch.
    always_comb begin
        state_d = state;
        case (state)
            ST_IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    state_d = last_owner ? ST_OWN0 : ST_OWN1;
                end else if (m0_cyc_i) begin
                    state_d = ST_OWN0;
                end else if (m1_cyc_i) begin
                    state_d = ST_OWN1;
                end
            end
            ST_OWN0: begin
                if (!m0_cyc_i)          state_d = ST_IDLE;
                else if (stall_expired) state_d = ST_ABORT;
            end
            ST_OWN1: begin
                if (!m1_cyc_i)          state_d = ST_IDLE;
                else if (stall_expired) state_d = ST_ABORT;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= ST_IDLE;
            last_owner <= 1'b0;
            owner      <= 1'b0;
        end else begin
            state <= state_d;
            if (state == ST_IDLE && state_d != ST_IDLE) begin
                owner <= (state_d == ST_OWN1);
            end
            if (state != ST_IDLE && state_d == ST_IDLE) begin
                last_owner <= owner;
            end
        end
    end

    // Slave bus follows the owner; everything is zero in IDLE and ABORT.
    always_comb begin
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        s_cti_o = '0;
        s_bte_o = '0;
        if (own0) begin
            s_cyc_o = m0_cyc_i;
            s_stb_o = m0_stb_i;
            s_we_o  = m0_we_i;
            s_adr_o = m0_adr_i;
            s_dat_o = m0_dat_i;
            s_sel_o = m0_sel_i;
            s_cti_o = m0_cti_i;
            s_bte_o = m0_bte_i;
        end else if (own1) begin
            s_cyc_o = m1_cyc_i;
            s_stb_o = m1_stb_i;
            s_we_o  = m1_we_i;
            s_adr_o = m1_adr_i;
            s_dat_o = m1_dat_i;
            s_sel_o = m1_sel_i;
            s_cti_o = m1_cti_i;
            s_bte_o = m1_bte_i;
        end
    end

    assign m0_ack_o = own0 && s_ack_i;
    assign m0_rty_o = own0 && s_rty_i;
    assign m0_err_o = (own0 && s_err_i) || (aborting && !owner);
    assign m1_ack_o = own1 && s_ack_i;
    assign m1_rty_o = own1 && s_rty_i;
    assign m1_err_o = (own1 && s_err_i) || (aborting && owner);
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

    assign grant_o   = grant_of(state);
    assign timeout_o = aborting;

    assign stall_en  = owned && s_stb_o && !term;
    assign stall_clr = !owned || term;

    wb_bus_watchdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .en      (stall_en),
        .clr     (stall_clr),
        .expired (stall_expired)
    );

endmodule

// File: tb/tb_wb_cpu_bus_arbiter.sv
// Self-checking bench for wb_cpu_bus_arbiter: directed scenarios followed by
// randomized traffic compared against a cycle-level ownership model.
module tb_wb_cpu_bus_arbiter;
    import wb_soc_arb_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TMO = 4;

    logic clk_i = 1'b0;
    logic rst_i;
    logic m0_cyc_i, m0_stb_i, m0_we_i, m1_cyc_i, m1_stb_i, m1_we_i;
    logic [AW-1:0] m0_adr_i, m1_adr_i, s_adr_o;
    logic [DW-1:0] m0_dat_i, m1_dat_i, m0_dat_o, m1_dat_o, s_dat_o, s_dat_i;
    logic [3:0] m0_sel_i, m1_sel_i, s_sel_o;
    logic [2:0] m0_cti_i, m1_cti_i, s_cti_o;
    logic [1:0] m0_bte_i, m1_bte_i, s_bte_o, grant_o;
    logic m0_ack_o, m0_err_o, m0_rty_o, m1_ack_o, m1_err_o, m1_rty_o;
    logic s_cyc_o, s_stb_o, s_we_o, s_ack_i, s_err_i, s_rty_i, timeout_o;

    int total = 0;
    int bad = 0;

    always #5 clk_i = ~clk_i;

    wb_cpu_bus_arbiter #(
        .ADDRESS_WIDTH (AW), .DATA_WIDTH (DW), .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk_i (clk_i), .rst_i (rst_i),
        .m0_cyc_i (m0_cyc_i), .m0_stb_i (m0_stb_i), .m0_we_i (m0_we_i),
        .m0_adr_i (m0_adr_i), .m0_dat_i (m0_dat_i), .m0_sel_i (m0_sel_i),
        .m0_cti_i (m0_cti_i), .m0_bte_i (m0_bte_i),
        .m0_ack_o (m0_ack_o), .m0_err_o (m0_err_o), .m0_rty_o (m0_rty_o),
        .m0_dat_o (m0_dat_o),
        .m1_cyc_i (m1_cyc_i), .m1_stb_i (m1_stb_i), .m1_we_i (m1_we_i),
        .m1_adr_i (m1_adr_i), .m1_dat_i (m1_dat_i), .m1_sel_i (m1_sel_i),
        .m1_cti_i (m1_cti_i), .m1_bte_i (m1_bte_i),
        .m1_ack_o (m1_ack_o), .m1_err_o (m1_err_o), .m1_rty_o (m1_rty_o),
        .m1_dat_o (m1_dat_o),
        .s_cyc_o (s_cyc_o), .s_stb_o (s_stb_o), .s_we_o (s_we_o),
        .s_adr_o (s_adr_o), .s_dat_o (s_dat_o), .s_sel_o (s_sel_o),
        .s_cti_o (s_cti_o), .s_bte_o (s_bte_o),
        .s_ack_i (s_ack_i), .s_err_i (s_err_i), .s_rty_i (s_rty_i),
        .s_dat_i (s_dat_i),
        .grant_o (grant_o), .timeout_o (timeout_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks run 1 unit later.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_inputs();
        {m0_cyc_i, m0_stb_i, m0_we_i, m1_cyc_i, m1_stb_i, m1_we_i} = '0;
        m0_adr_i = '0; m0_dat_i = '0; m0_sel_i = '0; m0_cti_i = '0; m0_bte_i = '0;
        m1_adr_i = '0; m1_dat_i = '0; m1_sel_i = '0; m1_cti_i = '0; m1_bte_i = '0;
        {s_ack_i, s_err_i, s_rty_i} = '0;
        s_dat_i = '0;
    endtask

    // Reference model state: who holds the bus (-1 = nobody), pending abort.
    int  mdl_owner, mdl_last, mdl_stall, mdl_abort_who;
    bit  mdl_aborting;

    initial begin
        logic cyc [2];
        logic [AW-1:0] adr [2];
        logic [2:0] cti_end;
        bit   resp;

        clear_inputs();
        rst_i = 1'b1;
        tick(); tick();
        check("rst_grant", 32'(grant_o), 32'd0);
        check("rst_timeout", 32'(timeout_o), 32'd0);
        check("rst_s_cyc", 32'(s_cyc_o), 32'd0);
        check("rst_acks", 32'({m0_ack_o, m0_err_o, m1_ack_o, m1_err_o}), 32'd0);
        rst_i = 1'b0;

        // Single m0 read at 0x100, slave answers on the third owned cycle.
        m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h100; m0_sel_i = 4'hf;
        #1 check("rd_grant_lat0", 32'(grant_o), 32'd0);
        check("rd_s_cyc_lat0", 32'(s_cyc_o), 32'd0);
        tick();
        check("rd_grant", 32'(grant_o), 32'd1);
        check("rd_s_cyc", 32'(s_cyc_o), 32'd1);
        check("rd_s_adr", s_adr_o, 32'h100);
        tick(); tick();
        s_ack_i = 1; s_dat_i = 32'hcafe_f00d;
        #1 check("rd_m0_ack", 32'(m0_ack_o), 32'd1);
        check("rd_m1_ack", 32'(m1_ack_o), 32'd0);
        check("rd_m0_dat", m0_dat_o, 32'hcafe_f00d);
        check("rd_m1_dat", m1_dat_o, 32'hcafe_f00d);
        tick();
        clear_inputs();
        tick();
        check("rd_idle_grant", 32'(grant_o), 32'd0);

        // Simultaneous request after reset: m1 first, dead cycle, then m0.
        rst_i = 1; tick(); rst_i = 0;
        m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 32'h2000;
        tick();
        s_ack_i = 1;
        #1 check("tie_grant_m1", 32'(grant_o), 32'd2);
        check("tie_m1_ack", 32'(m1_ack_o), 32'd1);
        check("tie_m0_ack", 32'(m0_ack_o), 32'd0);
        check("tie_s_adr", s_adr_o, 32'h2000);
        tick();
        m1_cyc_i = 0; m1_stb_i = 0; s_ack_i = 0;
        tick();
        check("tie_dead_cycle", 32'(grant_o), 32'd0);
        check("tie_dead_s_cyc", 32'(s_cyc_o), 32'd0);
        tick();
        check("tie_grant_m0", 32'(grant_o), 32'd1);
        m0_cyc_i = 0; m0_stb_i = 0;
        tick();

        // m0 four-beat burst while m1 waits: no preemption, all acks to m0.
        cti_end = CTI_END_OF_BURST;
        m0_cyc_i = 1; m0_stb_i = 1; m0_cti_i = CTI_INCR_BURST;
        tick();
        m1_cyc_i = 1; m1_stb_i = 1; s_ack_i = 1;
        for (int b = 0; b < 4; b++) begin
            m0_cti_i = (b < 3) ? CTI_INCR_BURST : cti_end;
            m0_adr_i = 32'h400 + 32'(4 * b);
            #1 check("burst_grant", 32'(grant_o), 32'd1);
            check("burst_m0_ack", 32'(m0_ack_o), 32'd1);
            check("burst_m1_ack", 32'(m1_ack_o), 32'd0);
            check("burst_s_cti", 32'(s_cti_o), 32'(m0_cti_i));
            tick();
        end
        m0_cyc_i = 0; m0_stb_i = 0; s_ack_i = 0;
        #1 check("burst_no_preempt", 32'(grant_o), 32'd1);
        tick();
        check("burst_dead_cycle", 32'(grant_o), 32'd0);
        tick();
        check("burst_m1_after", 32'(grant_o), 32'd2);
        m1_cyc_i = 0; m1_stb_i = 0;
        tick();

        // m1 write to a silent slave: four stall cycles, then ABORT.
        m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 1; m1_adr_i = 32'h3000;
        tick();
        for (int k = 1; k <= TMO; k++) begin
            check("tmo_stall_grant", 32'(grant_o), 32'd2);
            check("tmo_stall_flags", 32'({timeout_o, m1_err_o}), 32'd0);
            tick();
        end
        check("tmo_m1_err", 32'(m1_err_o), 32'd1);
        check("tmo_pulse", 32'(timeout_o), 32'd1);
        check("tmo_m0_err", 32'(m0_err_o), 32'd0);
        check("tmo_grant", 32'(grant_o), 32'd0);
        check("tmo_s_cyc", 32'(s_cyc_o), 32'd0);
        m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0;
        tick();
        check("tmo_after", 32'({timeout_o, m1_err_o, grant_o}), 32'd0);

        // Ack on exactly the limit stall cycle wins over the timeout.
        m0_cyc_i = 1; m0_stb_i = 1;
        tick();
        tick(); tick(); tick();
        s_ack_i = 1;
        #1 check("edge_ack", 32'(m0_ack_o), 32'd1);
        check("edge_no_tmo", 32'({timeout_o, m0_err_o}), 32'd0);
        tick();
        m0_cyc_i = 0; m0_stb_i = 0; s_ack_i = 0;
        #1 check("edge_hold", 32'({timeout_o, grant_o}), 32'd1);
        tick();
        check("edge_idle", 32'({timeout_o, grant_o}), 32'd0);

        // Reset in the middle of an acked burst: no termination afterwards.
        m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h800; m0_cti_i = CTI_INCR_BURST;
        tick();
        s_ack_i = 1;
        tick(); tick();
        rst_i = 1;
        tick();
        check("rst_mid_grant", 32'(grant_o), 32'd0);
        check("rst_mid_s_bus", 32'({s_cyc_o, s_stb_o, s_we_o}), 32'd0);
        check("rst_mid_s_adr", s_adr_o, 32'd0);
        check("rst_mid_term", 32'({m0_ack_o, m0_err_o, m0_rty_o, m1_ack_o, m1_err_o, m1_rty_o}), 32'd0);
        check("rst_mid_tmo", 32'(timeout_o), 32'd0);
        clear_inputs();
        tick();
        rst_i = 0;

        // Randomized traffic against the ownership model.
        mdl_owner = -1; mdl_last = 0; mdl_stall = 0; mdl_aborting = 0; mdl_abort_who = 0;
        for (int n = 0; n < 3000; n++) begin
            rst_i = ($urandom_range(0, 249) == 0);
            m0_cyc_i = m0_cyc_i ? ($urandom_range(0, 5) != 0) : ($urandom_range(0, 2) == 0);
            m1_cyc_i = m1_cyc_i ? ($urandom_range(0, 5) != 0) : ($urandom_range(0, 2) == 0);
            m0_stb_i = m0_cyc_i; m1_stb_i = m1_cyc_i;
            m0_we_i = 1'($urandom); m1_we_i = 1'($urandom);
            m0_adr_i = $urandom; m1_adr_i = $urandom;
            m0_dat_i = $urandom; m1_dat_i = $urandom; s_dat_i = $urandom;
            case ($urandom_range(0, 11))
                0, 1, 2: {s_ack_i, s_err_i, s_rty_i} = 3'b100;
                3:       {s_ack_i, s_err_i, s_rty_i} = 3'b010;
                4:       {s_ack_i, s_err_i, s_rty_i} = 3'b001;
                default: {s_ack_i, s_err_i, s_rty_i} = 3'b000;
            endcase
            cyc[0] = m0_cyc_i; cyc[1] = m1_cyc_i;
            adr[0] = m0_adr_i; adr[1] = m1_adr_i;
            resp = s_ack_i || s_err_i || s_rty_i;
            #1;
            check("rnd_grant", 32'(grant_o),
                  (mdl_owner == 0) ? 32'd1 : (mdl_owner == 1) ? 32'd2 : 32'd0);
            check("rnd_s_cyc", 32'(s_cyc_o), (mdl_owner >= 0) ? 32'(cyc[mdl_owner]) : 32'd0);
            check("rnd_s_adr", s_adr_o, (mdl_owner >= 0) ? adr[mdl_owner] : 32'd0);
            check("rnd_timeout", 32'(timeout_o), 32'(mdl_aborting));
            check("rnd_m0_term", 32'({m0_ack_o, m0_err_o, m0_rty_o}),
                  32'({mdl_owner == 0 && s_ack_i,
                       (mdl_owner == 0 && s_err_i) || (mdl_aborting && mdl_abort_who == 0),
                       mdl_owner == 0 && s_rty_i}));
            check("rnd_m1_term", 32'({m1_ack_o, m1_err_o, m1_rty_o}),
                  32'({mdl_owner == 1 && s_ack_i,
                       (mdl_owner == 1 && s_err_i) || (mdl_aborting && mdl_abort_who == 1),
                       mdl_owner == 1 && s_rty_i}));
            check("rnd_m1_dat", m1_dat_o, s_dat_i);

            // Advance the model across the coming edge.
            if (rst_i) begin
                mdl_owner = -1; mdl_last = 0; mdl_stall = 0; mdl_aborting = 0;
            end else if (mdl_aborting) begin
                mdl_aborting = 0;
                mdl_last = mdl_abort_who;
            end else if (mdl_owner >= 0) begin
                if (!cyc[mdl_owner]) begin
                    mdl_last = mdl_owner; mdl_owner = -1; mdl_stall = 0;
                end else if (resp) begin
                    mdl_stall = 0;
                end else begin
                    mdl_stall++;
                    if (mdl_stall == TMO) begin
                        mdl_aborting = 1; mdl_abort_who = mdl_owner;
                        mdl_owner = -1; mdl_stall = 0;
                    end
                end
            end else if (cyc[0] && cyc[1]) begin
                mdl_owner = (mdl_last == 0) ? 1 : 0;
            end else if (cyc[0]) begin
                mdl_owner = 0;
            end else if (cyc[1]) begin
                mdl_owner = 1;
            end
            @(posedge clk_i);
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
